// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, MEM-stage branch/jump flush,
// and a data-memory req/ack freeze with a timeout watchdog and debug stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned W   = 5,
  parameter int unsigned TMO = 16,
  parameter int unsigned CW  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          idex_MemRead,
  input  logic [W-1:0]  idex_rt,
  input  logic [W-1:0]  ifid_rs,
  input  logic [W-1:0]  ifid_rt,
  input  logic          exmem_Jump,
  input  logic          exmem_Branch,
  input  logic          exmem_BranchNot,
  input  logic          exmem_zero,
  input  logic          exmem_MemRead,
  input  logic          exmem_MemWrite,
  input  logic          dmem_ack,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          idex_write,
  output logic          exmem_write,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          exmem_flush,
  output logic          memwb_bubble,
  output logic          pc_src,
  output logic          dmem_req,
  output logic          mem_err,
  output logic [CW-1:0] stall_cnt,
  output logic          state
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  localparam int unsigned WCW = $clog2(TMO);
  localparam logic [WCW-1:0] WLAST = WCW'(TMO - 1);

  state_t         st, st_nx;
  logic [WCW-1:0] wcnt;
  logic           mem_acc, taken, lu, tmo_hit, freeze;

  assign mem_acc = exmem_MemRead | exmem_MemWrite;
  assign taken   = exmem_Jump | (exmem_Branch & exmem_zero) | (exmem_BranchNot & ~exmem_zero);
  assign lu      = idex_MemRead & (idex_rt != '0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Timeout cycle behaves like an ack: freeze released, request still shown.
  assign tmo_hit = (st == MEMWAIT) & ~dmem_ack & (wcnt == WLAST);
  assign freeze  = ((st == RUN) & mem_acc & ~dmem_ack) |
                   ((st == MEMWAIT) & ~dmem_ack & ~tmo_hit);

  assign state = (st == MEMWAIT);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    pc_src       = 1'b0;
    dmem_req     = (st == MEMWAIT) | mem_acc;
    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      pc_src       = 1'b0;
      dmem_req     = 1'b0;
    end
  end

  always_comb begin
    st_nx = st;
    case (st)
      RUN:     if (mem_acc & ~dmem_ack) st_nx = MEMWAIT;
      MEMWAIT: if (dmem_ack | tmo_hit)  st_nx = RUN;
      default: st_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= RUN;
      wcnt      <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      st <= st_nx;
      if (st == RUN || dmem_ack || tmo_hit)
        wcnt <= '0;
      else
        wcnt <= wcnt + 1'b1;
      if (tmo_hit)
        mem_err <= 1'b1;
      if (!pc_write && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       idex_MemRead;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       exmem_Jump, exmem_Branch, exmem_BranchNot, exmem_zero;
  logic       exmem_MemRead, exmem_MemWrite, dmem_ack;
  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble;
  logic       pc_src, dmem_req, mem_err, state;
  logic [3:0] stall_cnt;

  pipe_hazard_ctrl #(.W(5), .TMO(4), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_Jump(exmem_Jump), .exmem_Branch(exmem_Branch),
    .exmem_BranchNot(exmem_BranchNot), .exmem_zero(exmem_zero),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .pc_src(pc_src),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, bubble, pc_src, req, err, state}
  localparam logic [11:0] E_RST  = 12'b0000_0000_0000;
  localparam logic [11:0] E_IDLE = 12'b1111_0000_0000;
  localparam logic [11:0] E_LU   = 12'b0011_0100_0000;
  localparam logic [11:0] E_TAKE = 12'b1111_1110_1000;
  localparam logic [11:0] E_FRZR = 12'b0000_0001_0100;
  localparam logic [11:0] E_FRZW = 12'b0000_0001_0101;
  localparam logic [11:0] E_RELW = 12'b1111_0000_0101;
  localparam logic [11:0] E_ZW   = 12'b1111_0000_0100;
  localparam logic [11:0] E_ERR  = 12'b0000_0000_0010;

  logic [11:0] exp_q[$];
  logic [3:0]  cnt_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  wire [11:0] act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
                     exmem_flush, memwb_bubble, pc_src, dmem_req, mem_err, state};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      logic [3:0]  c;
      string       n;
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s outputs: got %b required %b", n, act, e);
      end
      checks++;
      if (stall_cnt !== c) begin
        failures++;
        $display("FAIL %s stall_cnt: got %0d required %0d", n, stall_cnt, c);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the expected response.
  task automatic cyc(input string nm, input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                     input logic [4:0] rt, input logic j, input logic b, input logic bn,
                     input logic z, input logic emr, input logic emw, input logic ack,
                     input logic [11:0] e, input logic [3:0] sc);
    idex_MemRead = mr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
    exmem_Jump = j; exmem_Branch = b; exmem_BranchNot = bn; exmem_zero = z;
    exmem_MemRead = emr; exmem_MemWrite = emw; dmem_ack = ack;
    exp_q.push_back(e);
    cnt_q.push_back(sc);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    //   name            mr irt rs rt  j  b  bn z  emr emw ack exp            cnt
    cyc("reset",         0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_RST,          0);
    reset = 1'b0;
    cyc("idle",          0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         0);
    cyc("lu_rs",         1, 8, 8, 0,  0, 0, 0, 0, 0, 0, 0,  E_LU,           0);
    cyc("lu_after",      0, 8, 8, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         1);
    cyc("lu_rt",         1, 9, 0, 9,  0, 0, 0, 0, 0, 0, 0,  E_LU,           1);
    cyc("lu_r0",         1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         2);
    cyc("lu_nomatch",    1, 8, 7, 9,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         2);
    cyc("beq_taken",     0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 0,  E_TAKE,         2);
    cyc("bne_zero",      0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0,  E_IDLE,         2);
    cyc("bne_taken",     0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0,  E_TAKE,         2);
    cyc("beq_nottaken",  0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  E_IDLE,         2);
    cyc("jump",          0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0,  E_TAKE,         2);
    cyc("jump_and_lu",   1, 8, 8, 0,  1, 0, 0, 0, 0, 0, 0,  E_TAKE,         2);
    cyc("zero_wait",     0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1,  E_ZW,           2);
    cyc("stray_ack",     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1,  E_IDLE,         2);
    cyc("mw3_c1",        0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZR,         2);
    cyc("mw3_c2",        0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZW,         3);
    cyc("mw3_ack",       0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1,  E_RELW,         4);
    cyc("mw3_after",     0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         4);
    cyc("frz_br_c1",     1, 8, 8, 0,  0, 1, 0, 1, 0, 1, 0,  E_FRZR,         4);
    cyc("frz_br_rel",    1, 8, 8, 0,  0, 1, 0, 1, 0, 1, 1,  E_TAKE | 12'b101, 5);
    cyc("frz_lu_c1",     1, 8, 8, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZR,         5);
    cyc("frz_lu_rel",    1, 8, 8, 0,  0, 0, 0, 0, 1, 0, 1,  E_LU | 12'b101,   6);
    cyc("frz_lu_after",  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         7);
    cyc("tmo_c1",        0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZR,         7);
    cyc("tmo_c2",        0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZW,         8);
    cyc("tmo_c3",        0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZW,         9);
    cyc("tmo_c4",        0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZW,         10);
    cyc("tmo_release",   0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_RELW,         11);
    cyc("tmo_err",       0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE | E_ERR, 11);
    cyc("err_sticky",    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE | E_ERR, 11);
    cyc("rst_mw_c1",     0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZR | E_ERR, 11);
    cyc("rst_mw_c2",     0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  E_FRZW | E_ERR, 12);
    reset = 1'b1;
    cyc("rst_in_memwait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_RST,          0);
    reset = 1'b0;
    cyc("post_reset",    0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         0);
    for (int i = 0; i < 20; i++)
      cyc("sat_lu",      1, 8, 8, 0,  0, 0, 0, 0, 0, 0, 0,  E_LU, (i < 15) ? 4'(i) : 4'd15);
    cyc("sat_end",       0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  E_IDLE,         15);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. It drives the write-enable and flush inputs of the PC and the IF/ID, ID/EX and EX/MEM pipe registers, and it inserts the MEM/WB bubble. It resolves three conditions:

- load-use hazards;
- taken branches and jumps resolved in MEM;
- multi-cycle data-memory accesses, through a req/ack handshake with a timeout watchdog.

It also keeps a saturating stall counter for debug.

## Interface
Parameters:
- W, 5, register-address width
- TMO, 16, max cycles to wait for dmem_ack before abort (≥2)
- CW, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- idex_MemRead  in  1  instruction in EX is a load
- idex_rt  in  W  load destination in EX
- ifid_rs, ifid_rt  in  W each  source registers of instruction in ID
- exmem_Jump, exmem_Branch, exmem_BranchNot, exmem_zero  in  1 each  MEM-stage control-flow signals
- exmem_MemRead, exmem_MemWrite  in  1 each  MEM-stage memory access
- dmem_ack  in  1  data memory completes access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear-to-bubble
- memwb_bubble  out  1  load NOP into MEM/WB
- pc_src  out  1  select branch/jump target
- dmem_req  out  1  access request to data memory
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  CW  cycles with pc_write=0
- state  out  1  0=RUN, 1=MEMWAIT (debug)

The clock port is `clk`. Reset is `reset`, asynchronous and active-high.

## Operation
Definitions:
- mem_acc = exmem_MemRead | exmem_MemWrite
- taken = exmem_Jump | (exmem_Branch & exmem_zero) | (exmem_BranchNot & ~exmem_zero)
- lu = idex_MemRead & (idex_rt≠0) & (idex_rt==ifid_rs | idex_rt==ifid_rt)

Outputs are combinational from state and inputs. Default values: all writes=1, all flushes/bubble/pc_src/dmem_req=0.

Priority, highest first:
1. reset asserted: all writes=0, all other outputs 0 (async). state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
2. Freeze (state RUN & mem_acc & ~dmem_ack, or state MEMWAIT & ~dmem_ack & not timing out): pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, dmem_req=1.
3. taken (RUN, or the MEMWAIT release cycle): pc_src=1; ifid_flush=idex_flush=exmem_flush=1; pc_write=1.
4. lu: pc_write=0, ifid_write=0, idex_flush=1 (exactly one bubble; next cycle the load is in MEM).

State machine:
- RUN → MEMWAIT when mem_acc & ~dmem_ack.
- Zero-wait access (ack in the same cycle): dmem_req=1 for that cycle only, no stall.
- MEMWAIT: dmem_req held 1 and EX/MEM frozen, so the access signals stay stable.
- MEMWAIT → RUN on dmem_ack. In the ack cycle dmem_req=1, freeze is released, and rules 3/4 apply.
- Wait counter: cleared on entering MEMWAIT, +1 per MEMWAIT cycle.
- Timeout: if the counter reaches TMO-1 without ack, the next edge sets mem_err=1 (sticky until reset), returns to RUN, and clears the counter.
  - In the timeout cycle the freeze is released as if acked and dmem_req=1.
  - The next cycle has dmem_req=0.
- stall_cnt: +1 on every post-reset edge where pc_write=0. Saturates at 2^CW-1.

## Timing
- Hazard response has zero latency (combinational). State, counters and mem_err update on the clock edge.
- dmem_req may not drop while in MEMWAIT until the ack or timeout cycle.
- Reset mid-MEMWAIT: dmem_req deasserts immediately. After release, RUN with a clean counter.
- ack with no pending mem_acc in RUN is ignored.
- taken and lu together: the branch wins, and pc_write=1 because the load-use consumer is flushed.
- mem_acc and taken cannot be set by a single instruction. If both are set, the freeze wins and the branch is applied on release.

## Test plan
- lu: idex_MemRead=1, idex_rt=8, ifid_rs=8 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1. With idex_rt=0 → no stall.
- Branch: exmem_Branch=1, zero=1 → pc_src=1, three flushes=1, pc_write=1. BranchNot with zero=1 → no action.
- 3-cycle memory: exmem_MemRead=1, ack on the 3rd cycle → freeze and memwb_bubble for 2 cycles, state=1 for 2 cycles, dmem_req=1 for 3 cycles, stall_cnt=2, then RUN.
- Timeout with TMO=4 and no ack → mem_err=1 after the 4th freeze cycle, state=0, dmem_req=0 on the following cycle, mem_err stays 1.
- Reset asserted in MEMWAIT → all writes=0 and dmem_req=0 asynchronously. After deassert: state=0, stall_cnt=0, mem_err=0.
- Saturation with CW=4: 20 load-use cycles → stall_cnt=15.
